token_queue: RTL and testbench

//  Buffers 16-bit tokens {kind[15:8], value[7:0]} produced by the lexer stage and presents them to the parser.

---
 rtl/token_queue.sv | 126 ++++++++++++
 tb/tb_token_queue.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/token_queue.sv
// rtl/token_queue.sv - first-word-fall-through token FIFO between lexer and parser
module token_queue #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CLEAR,
  input  logic                  I_VALID,
  input  logic [DATA_W-1:0]     I_DATA,
  output logic                  O_VALID,
  input  logic                  O_READY,
  output logic [DATA_W-1:0]     O_DATA,
  output logic [DEPTH_LOG2:0]   COUNT,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  OVERFLOW,
  output logic [15:0]           TOKEN_CNT
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
  localparam logic [15:0]           TOKEN_MAX  = 16'hFFFF;

  // Token storage; contents are don't-care until written, so no reset.
  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  overflow_q;
  logic [15:0]           token_cnt_q;

  logic push_req;
  logic pop;
  logic push;
  logic drop;
  logic full_i;
  logic empty_i;

  // Status flags come only from the registered occupancy.
  always_comb begin
    full_i  = (count_q == COUNT_FULL);
    empty_i = (count_q == '0);
  end

  // Handshake decode: zero tokens are the lexer's idle code and are filtered.
  // A full queue still accepts a token when the head leaves in the same cycle.
  always_comb begin
    push_req = I_VALID && (I_DATA != '0);
    pop      = !empty_i && O_READY;
    push     = push_req && (!full_i || pop);
    drop     = push_req && full_i && !pop;
  end

  // Storage write; a flush in the same cycle discards the incoming token.
  always_ff @(posedge CLK) begin
    if (push && !CLEAR) begin
      mem[wr_ptr] <= I_DATA;
    end
  end

  // Write and read pointers wrap naturally at DEPTH.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (CLEAR) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Occupancy: simultaneous push and pop leave it unchanged.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= '0;
    end else if (CLEAR) begin
      count_q <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count_q <= count_q + COUNT_ONE;
        2'b01:   count_q <= count_q - COUNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overflow, set whenever a real token is dropped.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      overflow_q <= 1'b0;
    end else if (CLEAR) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end

  // Accepted-token counter, saturating so a long debug run never wraps.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      token_cnt_q <= '0;
    end else if (CLEAR) begin
      token_cnt_q <= '0;
    end else if (push && (token_cnt_q != TOKEN_MAX)) begin
      token_cnt_q <= token_cnt_q + 16'd1;
    end
  end

  // Fall-through head: the stored word at rd_ptr, forced to zero when empty.
  always_comb begin
    O_VALID   = !empty_i;
    O_DATA    = empty_i ? '0 : mem[rd_ptr];
    COUNT     = count_q;
    FULL      = full_i;
    EMPTY     = empty_i;
    OVERFLOW  = overflow_q;
    TOKEN_CNT = token_cnt_q;
  end

endmodule

// File: tb/tb_token_queue.sv
// tb/tb_token_queue.sv - scoreboard bench for token_queue
module tb_token_queue;

  logic        CLK;
  logic        RST;
  logic        CLEAR;
  logic        I_VALID;
  logic [15:0] I_DATA;
  logic        O_VALID;
  logic        O_READY;
  logic [15:0] O_DATA;
  logic [4:0]  COUNT;
  logic        FULL;
  logic        EMPTY;
  logic        OVERFLOW;
  logic [15:0] TOKEN_CNT;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  token_queue #(.DATA_W(16), .DEPTH_LOG2(4)) dut (
    .CLK(CLK), .RST(RST), .CLEAR(CLEAR),
    .I_VALID(I_VALID), .I_DATA(I_DATA),
    .O_VALID(O_VALID), .O_READY(O_READY), .O_DATA(O_DATA),
    .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY),
    .OVERFLOW(OVERFLOW), .TOKEN_CNT(TOKEN_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_tok(input logic [15:0] d, input bit accepted);
    I_VALID = 1'b1;
    I_DATA  = d;
    if (accepted) exp_q.push_back(d);
    cyc();
    I_VALID = 1'b0;
    I_DATA  = '0;
  endtask

  task automatic drain(input int n);
    O_READY = 1'b1;
    repeat (n) cyc();
    O_READY = 1'b0;
  endtask

  task automatic do_clear();
    CLEAR = 1'b1;
    exp_q.delete();
    cyc();
    CLEAR = 1'b0;
  endtask

  // Monitor: every head token that is handed over must match the scoreboard.
  always @(negedge CLK) begin
    if (!RST && O_VALID && O_READY) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", {16'h0, O_DATA}, 32'hDEAD_0000);
      end else begin
        chk("pop_data", {16'h0, O_DATA}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    RST = 1'b1; CLEAR = 1'b0; I_VALID = 1'b0; I_DATA = '0; O_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    // 1: async reset mid-clock with tokens buffered
    push_tok(16'h0A01, 1'b1);
    push_tok(16'h0A02, 1'b1);
    chk("pre_reset_count", COUNT, 2);
    #2 RST = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_count", COUNT, 0);
    chk("rst_empty", EMPTY, 1);
    chk("rst_full", FULL, 0);
    chk("rst_ovalid", O_VALID, 0);
    chk("rst_odata", O_DATA, 0);
    chk("rst_overflow", OVERFLOW, 0);
    chk("rst_tokcnt", TOKEN_CNT, 0);
    #1 RST = 1'b0;
    cyc();

    // 2: single token, hold then pop
    push_tok(16'h0100, 1'b1);
    chk("t2_ovalid", O_VALID, 1);
    chk("t2_odata", O_DATA, 16'h0100);
    chk("t2_count", COUNT, 1);
    chk("t2_tokcnt", TOKEN_CNT, 1);
    cyc();
    chk("t2_hold_odata", O_DATA, 16'h0100);
    drain(1);
    chk("t2_empty", EMPTY, 1);
    chk("t2_odata_zero", O_DATA, 0);

    // 3: zero tokens filtered
    do_clear();
    I_VALID = 1'b1; I_DATA = 16'h0000;
    repeat (5) cyc();
    I_VALID = 1'b0;
    chk("t3_count", COUNT, 0);
    chk("t3_tokcnt", TOKEN_CNT, 0);
    chk("t3_overflow", OVERFLOW, 0);

    // 4: fill past capacity, 17th token dropped
    for (int i = 1; i <= 17; i++) push_tok(16'h0200 + 16'(i), i <= 16);
    chk("t4_count", COUNT, 16);
    chk("t4_full", FULL, 1);
    chk("t4_overflow", OVERFLOW, 1);
    chk("t4_tokcnt", TOKEN_CNT, 16);
    drain(16);
    chk("t4_empty", EMPTY, 1);
    chk("t4_sb_empty", exp_q.size(), 0);
    chk("t4_overflow_sticky", OVERFLOW, 1);

    // 5: push+pop while full, then mixed traffic across pointer wrap
    do_clear();
    for (int i = 1; i <= 16; i++) push_tok(16'h0400 + 16'(i), 1'b1);
    O_READY = 1'b1;
    push_tok(16'h0300, 1'b1);
    O_READY = 1'b0;
    chk("t5_count", COUNT, 16);
    chk("t5_overflow", OVERFLOW, 0);
    chk("t5_tokcnt", TOKEN_CNT, 17);
    drain(16);
    chk("t5_sb_empty", exp_q.size(), 0);
    for (int i = 0; i < 40; i++) begin
      O_READY = (i % 3) != 0;
      I_VALID = (i % 4) != 3;
      I_DATA  = I_VALID ? 16'h0500 + 16'(i) : 16'h0000;
      if (I_VALID) exp_q.push_back(I_DATA);
      cyc();
    end
    I_VALID = 1'b0; I_DATA = '0;
    drain(16);
    chk("t5_mix_empty", EMPTY, 1);
    chk("t5_mix_sb_empty", exp_q.size(), 0);
    chk("t5_mix_tokcnt", TOKEN_CNT, 47);
    chk("t5_mix_overflow", OVERFLOW, 0);

    // 6: CLEAR beats a same-cycle push
    do_clear();
    for (int i = 1; i <= 17; i++) push_tok(16'h0600 + 16'(i), i <= 16);
    drain(11);
    chk("t6_pre_count", COUNT, 5);
    chk("t6_pre_overflow", OVERFLOW, 1);
    CLEAR = 1'b1; I_VALID = 1'b1; I_DATA = 16'h0777;
    exp_q.delete();
    cyc();
    CLEAR = 1'b0; I_VALID = 1'b0; I_DATA = '0;
    chk("t6_count", COUNT, 0);
    chk("t6_overflow", OVERFLOW, 0);
    chk("t6_tokcnt", TOKEN_CNT, 0);
    chk("t6_ovalid", O_VALID, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
